// File: rtl/cpu_stack_wb.sv
// cpu_stack_wb: stage-5 operand-stack writeback with registered top-of-stack and refill FSM
//   clk, rst         : clock, synchronous active-high reset
//   valid_4a         : stage-4 instruction ready to commit (held by upstream while busy_5a)
//   c__to_push_4a    : push select, nonzero = push st__to_push_4a after the pop
//   st__to_pop_4a    : number of entries to pop
//   st__to_push_4a   : {type,data} word to push
//   r0_5a, r1_5a     : top and second stack entries (zero when absent)
//   sp_5a            : entry count / next free index
//   busy_5a          : r0/r1 refill in progress, no commit accepted
//   err_underflow/err_overflow : sticky error flags
module cpu_stack_wb #(
    parameter int DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_4a,
    input  logic [2:0]  c__to_push_4a,
    input  logic [10:0] st__to_pop_4a,
    input  logic [34:0] st__to_push_4a,
    output logic [34:0] r0_5a,
    output logic [34:0] r1_5a,
    output logic [10:0] sp_5a,
    output logic        busy_5a,
    output logic        err_underflow,
    output logic        err_overflow
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, RD0, RD1} state_e;
    state_e state_q, state_d;
    logic [34:0] mem [DEPTH];
    logic [34:0] r0_q, r0_d, r1_q, r1_d;
    logic [10:0] sp_q, sp_d, base;
    logic uf_q, uf_d, of_q, of_d;
    logic commit, push, under, drop, push_done, refill;
    always_comb begin
        commit = valid_4a && state_q == IDLE;
        push = c__to_push_4a != 3'd0;
        under = st__to_pop_4a > sp_q;
        base = under ? 11'd0 : sp_q - st__to_pop_4a;
        drop = push && base == 11'(DEPTH);
        push_done = push && !drop;
        // Only these cases leave r0/r1 derivable from the old top and the pushed word.
        refill = !((st__to_pop_4a == 11'd0 && (!push || push_done)) ||
                   (st__to_pop_4a == 11'd1 && push_done && !under));
    end
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = state_q == IDLE ? ((commit && refill) ? RD0 : IDLE) :
                  state_q == RD0 ? RD1 : IDLE;
    end
    always_comb begin
        busy_5a = state_q != IDLE;
    end
    // A push on a refill commit already sits at mem[sp-1], so the RD0 read returns that word.
    always_comb begin
        sp_d = sp_q;
        r0_d = r0_q;
        r1_d = r1_q;
        uf_d = uf_q | (commit && under);
        of_d = of_q | (commit && drop);
        if (commit) begin
            sp_d = base + {10'd0, push_done};
            if (push_done) r0_d = st__to_push_4a;
            if (push_done && st__to_pop_4a == 11'd0) r1_d = r0_q;
        end
        if (state_q == RD0) r0_d = sp_q >= 11'd1 ? mem[AW'(sp_q - 11'd1)] : 35'h0;
        if (state_q == RD1) r1_d = sp_q >= 11'd2 ? mem[AW'(sp_q - 11'd2)] : 35'h0;
    end
    always_ff @(posedge clk) begin
        if (!rst && commit && push_done) mem[AW'(base)] <= st__to_push_4a;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q <= 11'd0;
            r0_q <= 35'h0;
            r1_q <= 35'h0;
            uf_q <= 1'b0;
            of_q <= 1'b0;
        end else begin
            sp_q <= sp_d;
            r0_q <= r0_d;
            r1_q <= r1_d;
            uf_q <= uf_d;
            of_q <= of_d;
        end
    end
    assign r0_5a = r0_q;
    assign r1_5a = r1_q;
    assign sp_5a = sp_q;
    assign err_underflow = uf_q;
    assign err_overflow = of_q;
endmodule

// File: tb/tb_cpu_stack_wb.sv
// tb_cpu_stack_wb: directed and randomized checks of cpu_stack_wb against a queue-based stack model
module tb_cpu_stack_wb;
    localparam int DEPTH = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic valid_4a = 1'b0;
    logic [2:0] c__to_push_4a = 3'd0;
    logic [10:0] st__to_pop_4a = 11'd0;
    logic [34:0] st__to_push_4a = 35'h0;
    logic [34:0] r0_5a, r1_5a;
    logic [10:0] sp_5a;
    logic busy_5a, err_underflow, err_overflow;
    int checks = 0;
    int errors = 0;
    logic [34:0] q[$];
    bit m_uf, m_of;

    cpu_stack_wb #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .valid_4a(valid_4a), .c__to_push_4a(c__to_push_4a),
        .st__to_pop_4a(st__to_pop_4a), .st__to_push_4a(st__to_push_4a),
        .r0_5a(r0_5a), .r1_5a(r1_5a), .sp_5a(sp_5a), .busy_5a(busy_5a),
        .err_underflow(err_underflow), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [34:0] exp_r0();
        return q.size() >= 1 ? q[q.size()-1] : 35'h0;
    endfunction

    function automatic logic [34:0] exp_r1();
        return q.size() >= 2 ? q[q.size()-2] : 35'h0;
    endfunction

    // Stack semantics: pop first (underflow empties and flags), then push unless full.
    task automatic model(input int p, input bit u, input logic [34:0] w, output bit refill);
        bit under, done;
        under = p > q.size();
        done = 1'b0;
        if (under) begin q.delete(); m_uf = 1'b1; end
        else repeat (p) void'(q.pop_back());
        if (u) begin
            if (q.size() == DEPTH) m_of = 1'b1;
            else begin q.push_back(w); done = 1'b1; end
        end
        refill = !((p == 0 && !u) || (p == 0 && done) || (p == 1 && done && !under));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        valid_4a = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        q.delete();
        m_uf = 1'b0;
        m_of = 1'b0;
    endtask

    // Presents one instruction, holds it until it commits, returns at the negedge after commit.
    task automatic issue(input int p, input bit u, input logic [34:0] w, output bit refill);
        int n = 0;
        valid_4a = 1'b1;
        st__to_pop_4a = 11'(p);
        c__to_push_4a = u ? 3'($urandom_range(1, 7)) : 3'd0;
        st__to_push_4a = w;
        while (busy_5a && n < 10) begin @(negedge clk); n++; end
        checks++;
        if (busy_5a) begin errors++; $display("FAIL issue_timeout busy=%b required 0", busy_5a); end
        @(negedge clk);
        valid_4a = 1'b0;
        model(p, u, w, refill);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy_5a && n < 10) begin n++; @(negedge clk); end
    endtask

    task automatic test_reset();
        do_reset();
        checks += 6;
        if (sp_5a !== 11'd0) begin errors++; $display("FAIL reset_sp got %0d want 0", sp_5a); end
        if (r0_5a !== 35'h0) begin errors++; $display("FAIL reset_r0 got %h want 0", r0_5a); end
        if (r1_5a !== 35'h0) begin errors++; $display("FAIL reset_r1 got %h want 0", r1_5a); end
        if (busy_5a !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_5a); end
        if (err_underflow !== 1'b0) begin errors++; $display("FAIL reset_uf got %b want 0", err_underflow); end
        if (err_overflow !== 1'b0) begin errors++; $display("FAIL reset_of got %b want 0", err_overflow); end
    endtask

    task automatic test_push_pair();
        bit rf;
        bit saw_busy = 1'b0;
        issue(0, 1, 35'h5, rf);
        saw_busy |= busy_5a;
        issue(0, 1, 35'h7, rf);
        saw_busy |= busy_5a;
        checks += 4;
        if (saw_busy) begin errors++; $display("FAIL push_pair_busy got 1 want 0"); end
        if (sp_5a !== 11'd2) begin errors++; $display("FAIL push_pair_sp got %0d want 2", sp_5a); end
        if (r0_5a !== 35'h7) begin errors++; $display("FAIL push_pair_r0 got %h want 7", r0_5a); end
        if (r1_5a !== 35'h5) begin errors++; $display("FAIL push_pair_r1 got %h want 5", r1_5a); end
    endtask

    task automatic test_alu_refill();
        bit rf;
        int n;
        issue(2, 1, 35'hC, rf);
        checks += 2;
        if (r0_5a !== 35'hC) begin errors++; $display("FAIL alu_r0_early got %h want c", r0_5a); end
        if (busy_5a !== 1'b1) begin errors++; $display("FAIL alu_busy_start got %b want 1", busy_5a); end
        wait_idle(n);
        checks += 4;
        if (n != 2) begin errors++; $display("FAIL alu_stall got %0d want 2", n); end
        if (r0_5a !== 35'hC) begin errors++; $display("FAIL alu_r0 got %h want c", r0_5a); end
        if (r1_5a !== 35'h0) begin errors++; $display("FAIL alu_r1 got %h want 0", r1_5a); end
        if (sp_5a !== 11'd1) begin errors++; $display("FAIL alu_sp got %0d want 1", sp_5a); end
    endtask

    task automatic test_pop3_held();
        bit rf;
        logic [34:0] w [4];
        do_reset();
        for (int i = 0; i < 4; i++) begin
            w[i] = {3'(i + 1), 32'hA000_0000 + 32'(i)};
            issue(0, 1, w[i], rf);
        end
        issue(3, 0, 35'h0, rf);
        valid_4a = 1'b1;
        c__to_push_4a = 3'd2;
        st__to_pop_4a = 11'd0;
        st__to_push_4a = 35'h1_2345_6789;
        @(negedge clk);
        checks += 5;
        if (busy_5a !== 1'b1) begin errors++; $display("FAIL pop3_busy_rd1 got %b want 1", busy_5a); end
        @(negedge clk);
        if (busy_5a !== 1'b0) begin errors++; $display("FAIL pop3_busy_end got %b want 0", busy_5a); end
        if (r0_5a !== w[0]) begin errors++; $display("FAIL pop3_r0 got %h want %h", r0_5a, w[0]); end
        if (r1_5a !== 35'h0) begin errors++; $display("FAIL pop3_r1 got %h want 0", r1_5a); end
        if (sp_5a !== 11'd1) begin errors++; $display("FAIL pop3_sp got %0d want 1", sp_5a); end
        @(negedge clk);
        valid_4a = 1'b0;
        model(0, 1, 35'h1_2345_6789, rf);
        checks += 3;
        if (sp_5a !== 11'd2) begin errors++; $display("FAIL next_sp got %0d want 2", sp_5a); end
        if (r0_5a !== 35'h1_2345_6789) begin errors++; $display("FAIL next_r0 got %h want 123456789", r0_5a); end
        if (r1_5a !== w[0]) begin errors++; $display("FAIL next_r1 got %h want %h", r1_5a, w[0]); end
    endtask

    task automatic test_errors();
        bit rf;
        int n;
        do_reset();
        issue(0, 1, 35'h3_0000_0011, rf);
        issue(5, 0, 35'h0, rf);
        wait_idle(n);
        checks += 4;
        if (err_underflow !== 1'b1) begin errors++; $display("FAIL uf_flag got %b want 1", err_underflow); end
        if (sp_5a !== 11'd0) begin errors++; $display("FAIL uf_sp got %0d want 0", sp_5a); end
        if (r0_5a !== 35'h0) begin errors++; $display("FAIL uf_r0 got %h want 0", r0_5a); end
        if (r1_5a !== 35'h0) begin errors++; $display("FAIL uf_r1 got %h want 0", r1_5a); end
        for (int i = 0; i < DEPTH; i++) issue(0, 1, 35'(32'hF00 + i), rf);
        checks++;
        if (err_overflow !== 1'b0) begin errors++; $display("FAIL of_early got %b want 0", err_overflow); end
        issue(0, 1, 35'h7_DEAD_BEEF, rf);
        wait_idle(n);
        checks += 5;
        if (err_overflow !== 1'b1) begin errors++; $display("FAIL of_flag got %b want 1", err_overflow); end
        if (sp_5a !== 11'(DEPTH)) begin errors++; $display("FAIL of_sp got %0d want %0d", sp_5a, DEPTH); end
        if (r0_5a !== exp_r0()) begin errors++; $display("FAIL of_r0 got %h want %h", r0_5a, exp_r0()); end
        if (r1_5a !== exp_r1()) begin errors++; $display("FAIL of_r1 got %h want %h", r1_5a, exp_r1()); end
        if (err_underflow !== 1'b1) begin errors++; $display("FAIL uf_sticky got %b want 1", err_underflow); end
        issue(1, 0, 35'h0, rf);
        wait_idle(n);
        checks++;
        if (r0_5a !== exp_r0()) begin errors++; $display("FAIL of_mem got %h want %h", r0_5a, exp_r0()); end
    endtask

    task automatic test_reset_mid_refill();
        bit rf;
        do_reset();
        issue(0, 1, 35'h1, rf);
        issue(0, 1, 35'h2, rf);
        issue(0, 1, 35'h3, rf);
        issue(2, 0, 35'h0, rf);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        m_uf = 1'b0;
        m_of = 1'b0;
        checks += 4;
        if (busy_5a !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy_5a); end
        if (sp_5a !== 11'd0) begin errors++; $display("FAIL midrst_sp got %0d want 0", sp_5a); end
        if (r0_5a !== 35'h0) begin errors++; $display("FAIL midrst_r0 got %h want 0", r0_5a); end
        if (r1_5a !== 35'h0) begin errors++; $display("FAIL midrst_r1 got %h want 0", r1_5a); end
        issue(0, 1, 35'h4_0000_00AA, rf);
        checks += 3;
        if (sp_5a !== 11'd1) begin errors++; $display("FAIL midrst_push_sp got %0d want 1", sp_5a); end
        if (r0_5a !== 35'h4_0000_00AA) begin errors++; $display("FAIL midrst_push_r0 got %h want 4000000aa", r0_5a); end
        if (busy_5a !== 1'b0) begin errors++; $display("FAIL midrst_push_busy got %b want 0", busy_5a); end
    endtask

    task automatic test_random();
        bit rf;
        int n, p;
        bit u;
        do_reset();
        for (int k = 0; k < 300; k++) begin
            p = ($urandom_range(0, 9) < 5) ? 0 : $urandom_range(1, 3);
            if ($urandom_range(0, 19) == 0) p = $urandom_range(4, 6);
            u = $urandom_range(0, 2) != 0;
            issue(p, u, {$urandom, $urandom} & 35'h7_FFFF_FFFF, rf);
            wait_idle(n);
            checks += 6;
            if (n != (rf ? 2 : 0)) begin errors++; $display("FAIL rnd_stall[%0d] got %0d want %0d", k, n, rf ? 2 : 0); end
            if (sp_5a !== 11'(q.size())) begin errors++; $display("FAIL rnd_sp[%0d] got %0d want %0d", k, sp_5a, q.size()); end
            if (r0_5a !== exp_r0()) begin errors++; $display("FAIL rnd_r0[%0d] got %h want %h", k, r0_5a, exp_r0()); end
            if (r1_5a !== exp_r1()) begin errors++; $display("FAIL rnd_r1[%0d] got %h want %h", k, r1_5a, exp_r1()); end
            if (err_underflow !== m_uf) begin errors++; $display("FAIL rnd_uf[%0d] got %b want %b", k, err_underflow, m_uf); end
            if (err_overflow !== m_of) begin errors++; $display("FAIL rnd_of[%0d] got %b want %b", k, err_overflow, m_of); end
        end
    endtask

    initial begin
        test_reset();
        test_push_pair();
        test_alu_refill();
        test_pop3_held();
        test_errors();
        test_reset_mid_refill();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
